spi_fifo_sync: RTL and testbench
================================

Name: spi_fifo_sync

Overview:
Parametrised synchronous FIFO for the SPI peripheral. It is the next-generation TX/RX buffer between the register interface and the shift engine. It adds configurable data width and depth, same-cycle read and write, almost-full/almost-empty thresholds, flush, and sticky overflow/underflow error flags. One instance sits on each SPI direction.

Parameters:
DATA_W, 8, bits per entry (1..32)
DEPTH, 8, number of entries; power of two, at least 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
AF_LEVEL, DEPTH-1, almost_full asserts when data_count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when data_count <= AE_LEVEL

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
fifo_en  in  1  global enable; when low, all state holds
flush  in  1  discard contents
wr_en  in  1  push request
wr_data  in  DATA_W  push data
rd_en  in  1  pop request
rd_data  out  DATA_W  popped data, registered
rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
data_count  out  ADDR_W+1  occupancy, 0..DEPTH
full  out  1  data_count == DEPTH
empty  out  1  data_count == 0
almost_full  out  1  data_count >= AF_LEVEL
almost_empty  out  1  data_count <= AE_LEVEL
overflow  out  1  sticky: push rejected
underflow  out  1  sticky: pop rejected
err_clr  in  1  clears overflow and underflow

Behaviour:
- Reset: clk edge with rst_n=0. Clears rd_ptr, wr_ptr, data_count, rd_data, rd_valid, overflow and underflow to 0. Storage is not reset.
- Flags full/empty/almost_* are combinational from data_count. After reset: empty=1, almost_empty=1, full=0, almost_full=0.
- fifo_en=0: pointers, count, storage, rd_data and error flags hold. rd_valid=0. Requests are ignored and do not set error flags. err_clr is also ignored.
- flush=1 (with fifo_en=1) has priority over push and pop in the same cycle. It zeroes the pointers and data_count, sets rd_valid=0 and holds rd_data. Error flags are unchanged.
- Pop accept: rd_en && !empty.
  - Next edge: rd_data <= mem[rd_ptr], rd_valid=1, rd_ptr+1.
  - Latency is 1 cycle: no fall-through, so a pop never sees data pushed in the same cycle.
- Push accept: wr_en && (!full || pop accepted this cycle).
  - mem[wr_ptr] <= wr_data, wr_ptr+1.
  - Push on full is therefore legal only when paired with an accepted pop.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are ADDR_W wide and wrap DEPTH-1 -> 0 by natural overflow. No compare-based wrap.
- Push while empty plus pop in the same cycle: pop rejected, push accepted, count becomes 1, underflow set.
- Errors:
  - overflow <= 1 when wr_en and push not accepted.
  - underflow <= 1 when rd_en and pop not accepted.
  - err_clr clears both. If a new error occurs in the same cycle as err_clr, the set wins.
- rd_valid is low on every cycle without an accepted pop.
- Reset mid-operation discards all content. After reset, the first pop of any new data returns data written after reset.

Decomposition:
- spi_defs package gets SPI_FIFO_DATA_W, SPI_FIFO_DEPTH and the default threshold constants.
- One sub-module, spi_fifo_mem: a DATA_W x DEPTH array with one write port and one registered read port. Its ports are clk, we, waddr, wdata, re, raddr, rdata.
- Pointer, count, flag and error logic stay in spi_fifo_sync.

Test Plan:
- Reset then idle -> data_count=0, empty=1, almost_empty=1, rd_data=0x00, overflow=0, underflow=0.
- Push 0x11..0x18 (DEPTH=8), then 9th push 0xAA -> full=1, count=8, overflow=1. Pop 8 -> rd_data 0x11..0x18 in order, each one cycle after rd_en, rd_valid pulses, 0xAA never appears.
- Full FIFO, push 0x55 and pop in the same cycle -> count stays 8, rd_data=0x11, overflow stays 0. After the remaining 8 pops, the last value is 0x55.
- Empty FIFO, push 0x3C and pop in the same cycle -> underflow=1, rd_valid=0, count=1. Next pop -> rd_data=0x3C.
- Wrap: 20 push/pop pairs with values 0..19 -> output sequence identical. almost_full asserts at count 7, almost_empty deasserts at count 2.
- Flush with 5 entries plus concurrent push -> count=0, empty=1, error flags unchanged. fifo_en=0 with wr_en=rd_en=1 -> no state change, no flags set.

Source files
------------

// File: rtl/spi_defs_pkg.sv
// rtl/spi_defs_pkg.sv - shared constants for the SPI FIFO buffers
package spi_defs;

    // Default geometry of one SPI direction buffer.
    localparam int SPI_FIFO_DATA_W   = 8;
    localparam int SPI_FIFO_DEPTH    = 8;

    // Default watermark thresholds, expressed as occupancy counts.
    localparam int SPI_FIFO_AF_LEVEL = SPI_FIFO_DEPTH - 1;
    localparam int SPI_FIFO_AE_LEVEL = 1;

endpackage

// File: rtl/spi_fifo_mem.sv
// rtl/spi_fifo_mem.sv - DATA_W x DEPTH storage, one write port, one registered read port
//
// Ports:
//   clk   in  system clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   re    in  read enable; rdata loads mem[raddr] on the edge
//   raddr in  read address
//   rdata out registered read data, holds when re is low
//
// Storage and rdata are deliberately not reset.
module spi_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: when waddr == raddr on the same edge, rdata gets
    // the old entry. The top relies on this for push+pop on a full FIFO.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_fifo_sync.sv
// rtl/spi_fifo_sync.sv - parametrised synchronous FIFO for one SPI direction
//
// Ports:
//   clk          in  system clock
//   rst_n        in  synchronous active-low reset
//   fifo_en      in  global enable; low holds all state
//   flush        in  discard contents (wins over push/pop)
//   wr_en        in  push request
//   wr_data      in  push data
//   rd_en        in  pop request
//   rd_data      out popped data, registered, 1-cycle latency
//   rd_valid     out pulse: rd_data updated this cycle
//   data_count   out occupancy 0..DEPTH
//   full         out data_count == DEPTH
//   empty        out data_count == 0
//   almost_full  out data_count >= AF_LEVEL
//   almost_empty out data_count <= AE_LEVEL
//   overflow     out sticky: push rejected
//   underflow    out sticky: pop rejected
//   err_clr      in  clears overflow/underflow (a same-cycle new error wins)
module spi_fifo_sync
    import spi_defs::*;
#(
    parameter int DATA_W   = SPI_FIFO_DATA_W,
    parameter int DEPTH    = SPI_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = SPI_FIFO_AE_LEVEL,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_en,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    // Set once a pop has loaded the read register since reset; until then
    // rd_data reads as zero because the memory's read register is unreset.
    logic              loaded_q, loaded_d;

    logic              pop_acc;
    logic              push_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    // A pop is judged against the pre-edge count, so data pushed this cycle
    // is never visible to a same-cycle pop. A push into a full FIFO is only
    // legal when it replaces an entry leaving through an accepted pop.
    assign pop_acc  = fifo_en & ~flush & rd_en & ~empty;
    assign push_acc = fifo_en & ~flush & wr_en & (~full | pop_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        loaded_d   = loaded_q | pop_acc;

        if (fifo_en) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_acc) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop_acc) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({push_acc, pop_acc})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                rd_valid_d = pop_acc;
                ovf_d = (wr_en & ~push_acc) | (ovf_q & ~err_clr);
                unf_d = (rd_en & ~pop_acc)  | (unf_q & ~err_clr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            loaded_q   <= loaded_d;
        end
    end

    // Write/read enables are qualified by rst_n so reset really holds storage
    // and the read register still.
    spi_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc & rst_n),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (pop_acc & rst_n),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign rd_data    = loaded_q ? mem_rdata : '0;
    assign rd_valid   = rd_valid_q;
    assign data_count = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_spi_fifo_sync.sv
// tb/tb_spi_fifo_sync.sv - self-checking bench for spi_fifo_sync with queue reference model
module tb_spi_fifo_sync;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_en;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [3:0]    data_count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    spi_fifo_sync dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_en      (fifo_en),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, plus the expected registered outputs.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        int sz;
        sz = mq.size();
        chk("data_count",   32'(data_count),   32'(sz));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("full",         32'(full),         32'(sz == DP));
        chk("almost_full",  32'(almost_full),  32'(sz >= DP - 1));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
        chk("rd_valid",     32'(rd_valid),     32'(m_valid));
        chk("rd_data",      32'(rd_data),      32'(m_data));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    // One clock: drive inputs, advance the model, clock, check away from the edge.
    task automatic cyc(input logic rst, input logic en, input logic fl,
                       input logic we, input logic [DW-1:0] wd,
                       input logic re, input logic ec);
        bit pop_ok;
        bit push_ok;
        rst_n   = ~rst;
        fifo_en = en;
        flush   = fl;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = ec;
        if (rst) begin
            mq.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (!en) begin
            m_valid = 1'b0;
        end else if (fl) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            pop_ok  = re && (mq.size() > 0);
            push_ok = we && ((mq.size() < DP) || pop_ok);
            if (pop_ok) m_data = mq.pop_front();
            m_valid = pop_ok;
            if (push_ok) mq.push_back(wd);
            m_ovf = (we && !push_ok) || (m_ovf && !ec);
            m_unf = (re && !pop_ok)  || (m_unf && !ec);
        end
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic push(input logic [DW-1:0] d);
        cyc(0, 1, 0, 1, d, 0, 0);
    endtask

    task automatic pop();
        cyc(0, 1, 0, 0, 8'h00, 1, 0);
    endtask

    task automatic idle_clr();
        cyc(0, 1, 0, 0, 8'h00, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; fifo_en = 1'b0; flush = 1'b0; wr_en = 1'b0;
        wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;

        // Reset then idle.
        cyc(1, 0, 0, 0, 8'h00, 0, 0);
        cyc(1, 1, 0, 1, 8'hFF, 1, 0);
        cyc(0, 1, 0, 0, 8'h00, 0, 0);
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_ae", 32'(almost_empty), 32'h1);

        // Fill, overflow attempt, drain in order.
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        push(8'hAA);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            pop();
            chk("drain_order", 32'(rd_data), 32'(8'h11 + i));
        end

        // Push+pop on full.
        idle_clr();
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        cyc(0, 1, 0, 1, 8'h55, 1, 0);
        chk("full_pp_data", 32'(rd_data), 32'h11);
        chk("full_pp_cnt", 32'(data_count), 32'h8);
        chk("full_pp_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) pop();
        chk("full_pp_last", 32'(rd_data), 32'h55);

        // Push+pop on empty.
        cyc(0, 1, 0, 1, 8'h3C, 1, 0);
        chk("empty_pp_unf", 32'(underflow), 32'h1);
        chk("empty_pp_vld", 32'(rd_valid), 32'h0);
        pop();
        chk("empty_pp_data", 32'(rd_data), 32'h3C);

        // Wrap with thresholds: fill to 7 / 8 then stream.
        idle_clr();
        for (int i = 0; i < 8; i++) begin
            push(8'(i));
            if (i == 1) chk("ae_at2", 32'(almost_empty), 32'h0);
            if (i == 5) chk("af_at6", 32'(almost_full), 32'h0);
            if (i == 6) chk("af_at7", 32'(almost_full), 32'h1);
        end
        for (int i = 8; i < 20; i++) cyc(0, 1, 0, 1, 8'(i), 1, 0);
        for (int i = 0; i < 8; i++) pop();
        chk("wrap_last", 32'(rd_data), 32'd19);

        // Flush with 5 entries plus concurrent push; underflow preset.
        pop();
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
        cyc(0, 1, 1, 1, 8'hEE, 1, 0);
        chk("flush_empty", 32'(empty), 32'h1);
        chk("flush_unf", 32'(underflow), 32'h1);

        // Disabled: requests and err_clr ignored.
        push(8'h42);
        cyc(0, 0, 0, 1, 8'h99, 1, 1);
        chk("dis_cnt", 32'(data_count), 32'h1);
        chk("dis_unf", 32'(underflow), 32'h1);

        // Reset mid-operation, then new data only.
        push(8'h43);
        cyc(1, 1, 0, 0, 8'h00, 0, 0);
        push(8'h77);
        pop();
        chk("post_rst_data", 32'(rd_data), 32'h77);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 6),
                8'($urandom),
                ($urandom_range(0, 9) < 5),
                ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
